// File: rtl/kbd_pkg.sv
// Shared constants and types for the keyboard seven-segment scan slice.
package kbd_pkg;

  // Active-low glyphs for a common-anode digit: [6:0]=g..a, [7]=dp (held off).
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_S     = 8'h92;

  // Hex glyphs, entry 0 in the least significant byte.
  localparam logic [15:0][7:0] HEX_GLYPH = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // Digit-slot assignment on the 8-digit bank.
  localparam logic [2:0] DIG_CODE_LO  = 3'd0;
  localparam logic [2:0] DIG_CODE_HI  = 3'd1;
  localparam logic [2:0] DIG_ASCII_LO = 3'd2;
  localparam logic [2:0] DIG_ASCII_HI = 3'd3;
  localparam logic [2:0] DIG_COUNT_LO = 3'd4;
  localparam logic [2:0] DIG_COUNT_HI = 3'd5;
  localparam logic [2:0] DIG_FLAGS    = 3'd6;
  localparam logic [2:0] DIG_UNUSED   = 3'd7;

  // Per-frame snapshot of everything the display shows.
  typedef struct packed {
    logic       segs_en;
    logic [7:0] code;
    logic [7:0] ascii;
    logic [7:0] count;
    logic       shift;
    logic       ctrl;
  } snap_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Nibble to active-low seven-segment glyph (dp off).
module hex_to_seg7
  import kbd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg_n
);

  // Table lookup of the hex glyph.
  always_comb begin
    seg_n = HEX_GLYPH[nibble];
  end

endmodule

// File: rtl/kbd_seg_scan.sv
// Time-multiplexed scan of the 8-digit keyboard status display.
// Optional anti-ghosting blanking at the start of every slot is built when
// KBD_SCAN_DEADTIME_EN is defined.
module kbd_seg_scan
  import kbd_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned DEAD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       segs_enable,
  input  logic [7:0] code_byte,
  input  logic [7:0] ascii_byte,
  input  logic [7:0] count_byte,
  input  logic       shift_flag,
  input  logic       ctrl_flag,
  output logic [7:0] seg_n,
  output logic [7:0] an_n,
  output logic [2:0] digit_idx,
  output logic       frame_tick
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

`ifdef KBD_SCAN_DEADTIME_EN
  localparam bit DEAD_EN = 1'b1;
`else
  localparam bit DEAD_EN = 1'b0;
`endif

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]       digit_idx_q, digit_idx_d;
  logic             frame_tick_q, frame_tick_d;
  snap_t            snap_q, snap_d;
  logic [7:0]       seg_n_q, seg_n_d;
  logic [7:0]       an_n_q, an_n_d;

  logic       slot_end;
  logic       frame_start;
  logic [3:0] nibble;
  logic [7:0] glyph;
  logic       lit;

  // Prescaler, slot sequencing and once-per-frame input snapshot.
  always_comb begin
    slot_end     = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
    frame_start  = slot_end && (digit_idx_q == DIG_UNUSED);
    div_cnt_d    = slot_end ? '0 : div_cnt_q + DIV_W'(1);
    digit_idx_d  = slot_end ? digit_idx_q + 3'd1 : digit_idx_q;
    frame_tick_d = frame_start;
    snap_d       = snap_q;
    if (frame_start) begin
      snap_d.segs_en = segs_enable;
      snap_d.code    = code_byte;
      snap_d.ascii   = ascii_byte;
      snap_d.count   = count_byte;
      snap_d.shift   = shift_flag;
      snap_d.ctrl    = ctrl_flag;
    end
  end

  // Pick the nibble for the upcoming slot from the upcoming snapshot, so the
  // new frame's content appears on the same edge that starts the frame.
  always_comb begin
    nibble = 4'h0;
    case (digit_idx_d)
      DIG_CODE_LO:  nibble = snap_d.code[3:0];
      DIG_CODE_HI:  nibble = snap_d.code[7:4];
      DIG_ASCII_LO: nibble = snap_d.ascii[3:0];
      DIG_ASCII_HI: nibble = snap_d.ascii[7:4];
      DIG_COUNT_LO: nibble = snap_d.count[3:0];
      DIG_COUNT_HI: nibble = snap_d.count[7:4];
      default:      nibble = 4'h0;
    endcase
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble),
    .seg_n  (glyph)
  );

  // Segment/anode drive for the upcoming cycle; a blank digit never lights its anode.
  always_comb begin
    seg_n_d = SEG_BLANK;
    an_n_d  = '1;
    lit     = 1'b0;
    case (digit_idx_d)
      DIG_CODE_LO, DIG_CODE_HI, DIG_ASCII_LO, DIG_ASCII_HI: begin
        if (snap_d.segs_en) begin
          seg_n_d = glyph;
          lit     = 1'b1;
        end
      end
      DIG_COUNT_LO, DIG_COUNT_HI: begin
        seg_n_d = glyph;
        lit     = 1'b1;
      end
      DIG_FLAGS: begin
        if (snap_d.ctrl) begin
          seg_n_d = SEG_C;
          lit     = 1'b1;
        end else if (snap_d.shift) begin
          seg_n_d = SEG_S;
          lit     = 1'b1;
        end
      end
      default: begin
        lit = 1'b0;
      end
    endcase
    if (DEAD_EN && (32'(div_cnt_d) < DEAD_CYCLES)) begin
      seg_n_d = SEG_BLANK;
      lit     = 1'b0;
    end
    if (lit) begin
      an_n_d = ~(8'h01 << digit_idx_d);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q    <= '0;
      digit_idx_q  <= '0;
      frame_tick_q <= 1'b0;
      snap_q       <= '0;
      seg_n_q      <= SEG_BLANK;
      an_n_q       <= '1;
    end else begin
      div_cnt_q    <= div_cnt_d;
      digit_idx_q  <= digit_idx_d;
      frame_tick_q <= frame_tick_d;
      snap_q       <= snap_d;
      seg_n_q      <= seg_n_d;
      an_n_q       <= an_n_d;
    end
  end

  assign seg_n      = seg_n_q;
  assign an_n       = an_n_q;
  assign digit_idx  = digit_idx_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_kbd_seg_scan.sv
// Self-checking bench for kbd_seg_scan; frame expectations are queued when
// the inputs for a frame are driven and checked cycle by cycle when it plays.
module tb_kbd_seg_scan;

`ifdef KBD_SCAN_DEADTIME_EN
  localparam bit          DEAD_EN = 1'b1;
  localparam int unsigned D       = 8;
`else
  localparam bit          DEAD_EN = 1'b0;
  localparam int unsigned D       = 4;
`endif
  localparam int unsigned DEAD = 2;

  logic       clk;
  logic       rst;
  logic       segs_enable;
  logic [7:0] code_byte;
  logic [7:0] ascii_byte;
  logic [7:0] count_byte;
  logic       shift_flag;
  logic       ctrl_flag;
  logic [7:0] seg_n;
  logic [7:0] an_n;
  logic [2:0] digit_idx;
  logic       frame_tick;

  kbd_seg_scan #(.SCAN_DIV(D), .DEAD_CYCLES(DEAD)) dut (
    .clk         (clk),
    .rst         (rst),
    .segs_enable (segs_enable),
    .code_byte   (code_byte),
    .ascii_byte  (ascii_byte),
    .count_byte  (count_byte),
    .shift_flag  (shift_flag),
    .ctrl_flag   (ctrl_flag),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .digit_idx   (digit_idx),
    .frame_tick  (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0][7:0] an;
    logic [7:0][7:0] seg;
  } frame_t;

  frame_t sb_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     frm      = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  function automatic frame_t frame_exp(input logic en, input logic [7:0] c, input logic [7:0] a,
                                       input logic [7:0] k, input logic sh, input logic ct);
    frame_t     f;
    logic [3:0] nib;
    f.an  = '1;
    f.seg = '1;
    for (int s = 0; s < 6; s++) begin
      case (s)
        0:       nib = c[3:0];
        1:       nib = c[7:4];
        2:       nib = a[3:0];
        3:       nib = a[7:4];
        4:       nib = k[3:0];
        default: nib = k[7:4];
      endcase
      if (s >= 4 || en) begin
        f.seg[s] = glyph(nib);
        f.an[s]  = 8'(~(8'h01 << s));
      end
    end
    if (ct) begin
      f.seg[6] = 8'hC6;
      f.an[6]  = 8'hBF;
    end else if (sh) begin
      f.seg[6] = 8'h92;
      f.an[6]  = 8'hBF;
    end
    return f;
  endfunction

  task automatic drive_frame(input logic en, input logic [7:0] c, input logic [7:0] a,
                             input logic [7:0] k, input logic sh, input logic ct);
    segs_enable = en;
    code_byte   = c;
    ascii_byte  = a;
    count_byte  = k;
    shift_flag  = sh;
    ctrl_flag   = ct;
    sb_q.push_back(frame_exp(en, c, a, k, sh, ct));
  endtask

  // Walks one whole frame, every cycle. Entry: the negedge before the frame
  // (or the release negedge when from_reset). Optionally drives the next
  // frame's inputs during the digit-2 slot.
  task automatic check_frame(input bit from_reset, input bit drive, input logic en,
                             input logic [7:0] c, input logic [7:0] a, input logic [7:0] k,
                             input logic sh, input logic ct);
    frame_t     f;
    logic [7:0] ea, es;
    bit         first;
    f = '1;
    chk($sformatf("f%0d_sb_depth", frm), sb_q.size(), 1);
    if (sb_q.size() > 0) f = sb_q.pop_front();
    if (!from_reset) @(negedge clk);
    for (int s = 0; s < 8; s++) begin
      for (int p = 0; p < int'(D); p++) begin
        if (s != 0 || p != 0) @(negedge clk);
        first = (s == 0 && p == 0);
        if ((first && from_reset) || (DEAD_EN && p < int'(DEAD))) begin
          ea = 8'hFF;
          es = 8'hFF;
        end else begin
          ea = f.an[s];
          es = f.seg[s];
        end
        chk($sformatf("f%0d_s%0d_p%0d_an", frm, s, p), an_n, ea);
        chk($sformatf("f%0d_s%0d_p%0d_seg", frm, s, p), seg_n, es);
        chk($sformatf("f%0d_s%0d_p%0d_idx", frm, s, p), digit_idx, s);
        chk($sformatf("f%0d_s%0d_p%0d_tick", frm, s, p), frame_tick, first && !from_reset);
        if (drive && s == 2 && p == int'(D) - 1) drive_frame(en, c, a, k, sh, ct);
      end
    end
    frm++;
  endtask

  initial begin
    rst         = 1'b1;
    segs_enable = 1'b0;
    code_byte   = 8'h00;
    ascii_byte  = 8'h00;
    count_byte  = 8'h00;
    shift_flag  = 1'b0;
    ctrl_flag   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_an", an_n, 8'hFF);
    chk("rst_seg", seg_n, 8'hFF);
    chk("rst_idx", digit_idx, 0);
    chk("rst_tick", frame_tick, 0);

    // Frame 0 after reset comes from the cleared snapshot.
    sb_q.push_back(frame_exp(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0));
    rst = 1'b0;
    check_frame(1'b1, 1'b1, 1'b1, 8'h1C, 8'h61, 8'h27, 1'b0, 1'b0);
    // Frame 1: code changes mid-frame, shift raised.
    check_frame(1'b0, 1'b1, 1'b1, 8'h3A, 8'h61, 8'h27, 1'b1, 1'b0);
    // Frame 2: shift only; ctrl joins for the next frame.
    check_frame(1'b0, 1'b1, 1'b1, 8'h3A, 8'h61, 8'h27, 1'b1, 1'b1);
    // Frame 3: ctrl wins; next frame blanks digits 0-3 and drops flags.
    check_frame(1'b0, 1'b1, 1'b0, 8'h3A, 8'h61, 8'h27, 1'b0, 1'b0);
    // Frame 4: digits 0-3 and 6 blank.
    check_frame(1'b0, 1'b1, 1'b0, 8'h3A, 8'h61, 8'h27, 1'b0, 1'b0);

    // Frame 5: reset for one cycle inside the digit-5 slot.
    repeat (5 * D + 2) @(negedge clk);
    chk("pre_rst_idx", digit_idx, 5);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_idx", digit_idx, 0);
    chk("mid_rst_an", an_n, 8'hFF);
    chk("mid_rst_seg", seg_n, 8'hFF);
    chk("mid_rst_tick", frame_tick, 0);
    sb_q.delete();
    sb_q.push_back(frame_exp(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0));
    rst = 1'b0;
    check_frame(1'b1, 1'b1, 1'b1, 8'h5E, 8'h0F, 8'h80, 1'b0, 1'b1);
    check_frame(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
